// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial RAM/IO bus controller serving instruction fetch (IF) and load/store (LS).
// Multi-byte transfers are little-endian; stores to IO space stall while the UART buffer is full.
module mem_arbiter_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    IF_BYTES   = 4,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h30000
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    rdy_in,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    if_valid,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_clear,
    output logic                    if_ready,
    output logic [8*IF_BYTES-1:0]   if_data,
    input  logic                    ls_valid,
    input  logic                    ls_wr,
    input  logic [1:0]              ls_size,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [31:0]             ls_wdata,
    output logic                    ls_done,
    output logic [31:0]             ls_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; LS has priority over IF
    // IF_RD  | instruction fetch read, one byte address per cycle plus one capture cycle
    // LS_RD  | load read, same timing as IF_RD
    // LS_WR  | store, one byte per cycle, may stall on IO-mapped bytes
    // DONE   | one-cycle done pulse for the owning channel
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_LS_RD,
        ST_LS_WR,
        ST_DONE
    } state_t;

    localparam int BUF_BYTES = (IF_BYTES > 4) ? IF_BYTES : 4;
    localparam int CNT_W     = 5;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    src_if_q, src_if_d;
    logic                    wr_q, wr_d;
    logic [8*BUF_BYTES-1:0]  buf_q, buf_d;
    logic [8*IF_BYTES-1:0]   if_data_q, if_data_d;
    logic [31:0]             ls_rdata_q, ls_rdata_d;

    logic [CNT_W-1:0]        ls_len;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    io_stall;
    logic                    if_ready_raw;
    logic                    ls_rd_done;
    logic [8*BUF_BYTES-1:0]  rd_buf_next;
    logic [7:0]              wr_byte;

    assign cur_addr     = addr_q + ADDR_WIDTH'(cnt_q);
    assign io_stall     = (state_q == ST_LS_WR) && (cur_addr >= IO_BASE) && io_buffer_full;
    // A flush in the DONE cycle suppresses the fetch result entirely.
    assign if_ready_raw = (state_q == ST_DONE) && src_if_q && !if_clear;
    assign ls_rd_done   = (state_q == ST_DONE) && !src_if_q && !wr_q;

    always_comb begin
        ls_len = CNT_W'(4);
        case (ls_size)
            2'd0:    ls_len = CNT_W'(1);
            2'd1:    ls_len = CNT_W'(2);
            default: ls_len = CNT_W'(4);
        endcase
    end

    // The byte addressed in cycle k arrives while the counter reads k+1.
    always_comb begin
        rd_buf_next = buf_q;
        for (int k = 0; k < BUF_BYTES; k++) begin
            if (cnt_q == CNT_W'(k + 1)) begin
                rd_buf_next[8*k +: 8] = mem_din;
            end
        end
    end

    always_comb begin
        wr_byte = wdata_q[7:0];
        case (cnt_q[1:0])
            2'd0: wr_byte = wdata_q[7:0];
            2'd1: wr_byte = wdata_q[15:8];
            2'd2: wr_byte = wdata_q[23:16];
            2'd3: wr_byte = wdata_q[31:24];
            default: wr_byte = wdata_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        src_if_d   = src_if_q;
        wr_d       = wr_q;
        buf_d      = buf_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (ls_valid) begin
                    state_d  = ls_wr ? ST_LS_WR : ST_LS_RD;
                    cnt_d    = '0;
                    len_d    = ls_len;
                    addr_d   = ls_addr;
                    wdata_d  = ls_wdata;
                    src_if_d = 1'b0;
                    wr_d     = ls_wr;
                    buf_d    = '0;
                end else if (if_valid && !if_clear) begin
                    state_d  = ST_IF_RD;
                    cnt_d    = '0;
                    len_d    = CNT_W'(IF_BYTES);
                    addr_d   = if_addr;
                    src_if_d = 1'b1;
                    wr_d     = 1'b0;
                    buf_d    = '0;
                end
            end
            ST_IF_RD, ST_LS_RD: begin
                if ((state_q == ST_IF_RD) && if_clear) begin
                    state_d = ST_IDLE;
                end else begin
                    buf_d = rd_buf_next;
                    if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LS_WR: begin
                if (!io_stall) begin
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (if_ready_raw) begin
                    if_data_d = buf_q[8*IF_BYTES-1:0];
                end
                if (ls_rd_done) begin
                    ls_rdata_d = buf_q[31:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            src_if_q   <= 1'b0;
            wr_q       <= 1'b0;
            buf_q      <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            src_if_q   <= src_if_d;
            wr_q       <= wr_d;
            buf_q      <= buf_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state_q)
            ST_IF_RD, ST_LS_RD: begin
                if (cnt_q < len_q) begin
                    mem_a = cur_addr;
                end
            end
            ST_LS_WR: begin
                mem_a    = cur_addr;
                mem_dout = wr_byte;
                mem_wr   = !io_stall && rdy_in;
            end
            default: begin
                mem_a    = '0;
                mem_dout = '0;
                mem_wr   = 1'b0;
            end
        endcase
    end

    // Read results are visible in the DONE cycle and held afterwards.
    assign if_ready = if_ready_raw && rdy_in;
    assign if_data  = if_ready_raw ? buf_q[8*IF_BYTES-1:0] : if_data_q;
    assign ls_done  = (state_q == ST_DONE) && !src_if_q && rdy_in;
    assign ls_rdata = ls_rd_done ? buf_q[31:0] : ls_rdata_q;

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Byte-serial memory controller for the RISC-V core. Sits between the 8-bit RAM/IO bus and two requesters: instruction fetch (IF) and load/store buffer (LS).
- Arbitrates between the two, with LS at fixed priority.
- Assembles and splits multi-byte little-endian transfers.
- Stalls IO writes while the UART buffer is full, and supports IF abort on pipeline flush.

Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- IF_BYTES, 4, bytes per instruction fetch (1..16); if_data width = 8*IF_BYTES.
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO-mapped.

Ports:
- clk_in  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes the block
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_wr  out  1  1=write, 0=read
- if_valid  in  1  IF request
- if_addr  in  ADDR_WIDTH  fetch address
- if_clear  in  1  flush: abort any IF transfer
- if_ready  out  1  one-cycle done pulse
- if_data  out  8*IF_BYTES  fetched bytes
- ls_valid  in  1  LS request
- ls_wr  in  1  1=store
- ls_size  in  2  0=1B, 1=2B, 2=4B; 3 is illegal
- ls_addr  in  ADDR_WIDTH  LS address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle done pulse
- ls_rdata  out  32  load data, zero-extended

Behaviour:
- Reset (rst=1 at edge), regardless of state:
  - All outputs go to 0 and the state goes to IDLE.
  - Any in-flight transfer is discarded with no done pulse.
- rdy_in=0: all registers hold, mem_wr forced to 0, no grant, no progress.
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
- Outputs in IDLE and DONE: mem_wr=0, mem_a=0, mem_dout=0.
- Grant (IDLE only, sampled at edge G):
  - If ls_valid=1, grant LS, even if if_valid=1.
  - Else if if_valid=1 and if_clear=0, grant IF.
  - Address, size, write data and direction are latched at G.
- N = IF_BYTES for IF; N = 1/2/4 for LS. Byte k lives at addr+k; byte 0 is the LSB.
- Read, cycles counted from G:
  - Cycles G+1..G+N: mem_a=addr+k, mem_wr=0.
  - RAM returns byte k one cycle after its address. It is captured at the end of cycle G+k+2, into bits [8k+7:8k].
  - Done pulse and data valid in cycle G+N+2 (state DONE).
- Write:
  - Cycles G+1..G+N: mem_a=addr+k, mem_dout=byte k, mem_wr=1.
  - ls_done pulses in cycle G+N+1.
- IO stall:
  - Applies in LS_WR when the current byte address >= IO_BASE and io_buffer_full=1.
  - mem_wr=0 and the byte counter holds; the write resumes in the cycle after io_buffer_full drops.
  - Reads are never stalled.
- DONE lasts exactly one cycle, then IDLE, so there is at least one IDLE cycle between transfers.
- Requester handshake:
  - Hold valid and the request fields stable until done.
  - Deassert valid in the cycle after done; it is sampled again only in IDLE.
- if_data / ls_rdata hold their last value until the next done for that channel.
- if_clear=1 at any edge while IF_RD or DONE-for-IF:
  - The next state is IDLE and if_ready stays 0.
  - No IF grant occurs on that edge.
  - LS transfers are unaffected by if_clear.
- Simultaneous LS and IF requests: LS is served first; IF waits in IDLE and is granted after LS DONE.
- Address wrap: addr+k wraps modulo 2^ADDR_WIDTH.
- ls_size=3: treated as 4B (no error output).

Test Plan:
- Reset, then IF fetch at 0x1000 (RAM bytes 13,05,00,00) -> mem_a 0x1000..0x1003 in cycles G+1..G+4; if_ready=1 with if_data=32'h00000513 in cycle G+6; one cycle only.
- ls_valid and if_valid asserted the same cycle, 2B load at 0x20 (bytes AA,BB) -> LS first, ls_rdata=32'h0000BBAA at G+4; IF granted on the edge after the following IDLE.
- 4B store 0xDEADBEEF to 0x100 -> mem_wr=1 with mem_dout EF,BE,AD,DE at 0x100..0x103; ls_done at G+5.
- 1B store 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 during the stall; write occurs the cycle after full drops; ls_done one cycle later.
- if_clear pulsed during IF byte 2 -> no if_ready; IDLE next cycle; a new IF to 0x2000 then completes normally.
- rst asserted mid LS store, after byte 1 -> all outputs 0 the next cycle; no ls_done; no further mem_wr.
